// File: rtl/slave_responder.sv
// Slave endpoint of the valid/ready write protocol: captures one (addr, value)
// per transfer into a small register file, with programmable ready latency and protocol checking.
module slave_responder #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 3,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] value_in,
  input  logic              handshake_in,
  input  logic [1:0]        wait_cfg,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        r_cnt;
  logic [ACK_W-1:0]  r_ack_cnt;
  logic [ADDR_W-1:0] r_addr_cap;
  logic [DATA_W-1:0] r_val_cap;
  logic              r_ready;
  logic              r_wr_done;
  logic [CNT_W-1:0]  r_wr_count;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        w_state_next;
  logic [1:0]        w_cnt_next;
  logic [ACK_W-1:0]  w_ack_cnt_next;
  logic              w_capture;
  logic              w_write;
  logic              w_err_set;
  logic              w_mismatch;

  assign w_mismatch = valid && ((addr_in != r_addr_cap) || (value_in != r_val_cap));

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_ack_cnt_next = r_ack_cnt;
    w_capture      = 1'b0;
    w_write        = 1'b0;
    w_err_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (handshake_in) w_err_set = 1'b1;
        if (valid) begin
          w_capture    = 1'b1;
          w_cnt_next   = wait_cfg;
          w_state_next = (wait_cfg == 2'd0) ? S_READY : S_WAIT;
        end
      end
      S_WAIT: begin
        if (handshake_in || w_mismatch) w_err_set = 1'b1;
        // A master withdrawing valid before acceptance aborts the transfer.
        if (!valid) begin
          w_err_set    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
          if (r_cnt == 2'd1) w_state_next = S_READY;
        end
      end
      S_READY: begin
        if (handshake_in || w_mismatch) w_err_set = 1'b1;
        if (!valid) begin
          w_err_set    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_write        = 1'b1;
          w_ack_cnt_next = '0;
          w_state_next   = S_ACK;
        end
      end
      S_ACK: begin
        // valid is still held by the interconnect here and is deliberately ignored.
        if (handshake_in) begin
          w_state_next = S_IDLE;
        end else if (r_ack_cnt == ACK_LAST) begin
          w_err_set    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_ack_cnt_next = r_ack_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ack_cnt  <= '0;
      r_addr_cap <= '0;
      r_val_cap  <= '0;
      r_ready    <= 1'b0;
      r_wr_done  <= 1'b0;
      r_wr_count <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_ack_cnt <= w_ack_cnt_next;
      r_ready   <= (w_state_next == S_READY);
      r_wr_done <= w_write;
      r_err     <= r_err | w_err_set;
      if (w_capture) begin
        r_addr_cap <= addr_in;
        r_val_cap  <= value_in;
      end
      if (w_write && (r_wr_count != COUNT_MAX)) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  // One register per entry so the whole file clears on the asynchronous reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= '0;
        end else if (w_write && (r_addr_cap == ADDR_W'(gi))) begin
          r_mem[gi] <= r_val_cap;
        end
      end
    end
  endgenerate

  assign ready    = r_ready;
  assign wr_done  = r_wr_done;
  assign wr_count = r_wr_count;
  assign err      = r_err;
  assign rd_data  = r_mem[rd_addr];

endmodule

// File: tb/tb_slave_responder.sv
// Directed bench for slave_responder: stimulus pushes expected write records,
// a negedge monitor pops them whenever wr_done pulses.
module tb_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] addr_in = '0;
  logic [2:0] value_in = '0;
  logic       handshake_in = 1'b0;
  logic [1:0] wait_cfg = '0;
  logic [2:0] rd_addr = '0;
  logic       ready;
  logic [2:0] rd_data;
  logic       wr_done;
  logic [7:0] wr_count;
  logic       err;

  typedef struct packed {
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_count = 0;
  logic [2:0] tb_mem [8];

  slave_responder #(.ADDR_W(3), .DATA_W(3), .CNT_W(8), .ACK_TIMEOUT(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .addr_in(addr_in), .value_in(value_in),
    .handshake_in(handshake_in), .wait_cfg(wait_cfg), .rd_addr(rd_addr),
    .ready(ready), .rd_data(rd_data), .wr_done(wr_done), .wr_count(wr_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every wr_done pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && wr_done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got wr_done=1, expected no write");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_wr_count", 32'(wr_count), 32'(e.cnt));
        check("done_err", 32'(err), 32'(e.err));
        $display("write observed: wr_count=%0d err=%0d", wr_count, err);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic push_exp(input logic [2:0] a, input logic [2:0] v, input logic e_err);
    exp_t e;
    if (exp_count < 255) exp_count++;
    e.cnt = 8'(exp_count);
    e.err = e_err;
    sb_q.push_back(e);
    tb_mem[a] = v;
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check(name, 32'(rd_data), 32'(tb_mem[i]));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    handshake_in = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_err", 32'(err), 0);
    for (int i = 0; i < 8; i++) tb_mem[i] = '0;
    exp_count = 0;
    sb_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [1:0] cfg, input logic [2:0] a, input logic [2:0] v,
                          input logic e_err);
    bit got;
    @(negedge clk);
    wait_cfg = cfg;
    addr_in  = a;
    value_in = v;
    valid    = 1'b1;
    push_exp(a, v, e_err);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = ready;
    end
    if (!got) begin
      check("write_ready_timeout", 0, 1);
      valid = 1'b0;
      void'(sb_q.pop_back());
    end else begin
      @(negedge clk);
      handshake_in = 1'b1;
      @(negedge clk);
      handshake_in = 1'b0;
      valid = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tb_mem[i] = '0;
    repeat (2) @(negedge clk);
    check("init_ready", 32'(ready), 0);
    check("init_wr_done", 32'(wr_done), 0);
    check("init_wr_count", 32'(wr_count), 0);
    check("init_err", 32'(err), 0);
    rst_n = 1'b1;

    // Zero wait: ready one cycle after valid is sampled, wr_done the cycle after.
    @(negedge clk);
    wait_cfg = 2'd0; addr_in = 3'd5; value_in = 3'd6; valid = 1'b1;
    push_exp(3'd5, 3'd6, 1'b0);
    check("t1_ready_before", 32'(ready), 0);
    @(negedge clk);
    check("t1_ready_lat", 32'(ready), 1);
    @(negedge clk);
    check("t1_ready_drop", 32'(ready), 0);
    check("t1_wr_done", 32'(wr_done), 1);
    handshake_in = 1'b1;
    @(negedge clk);
    handshake_in = 1'b0; valid = 1'b0;
    check("t1_wr_done_pulse", 32'(wr_done), 0);
    rd_addr = 3'd5;
    #1;
    check("t1_rd_data", 32'(rd_data), 6);
    check("t1_wr_count", 32'(wr_count), 1);
    check("t1_err", 32'(err), 0);

    // wait_cfg=3, changed mid-transfer; valid held through S_ack with handshake.
    @(negedge clk);
    wait_cfg = 2'd3; addr_in = 3'd2; value_in = 3'd7; valid = 1'b1;
    push_exp(3'd2, 3'd7, 1'b0);
    @(negedge clk);
    wait_cfg = 2'd0;
    check("t2_ready_w1", 32'(ready), 0);
    @(negedge clk);
    check("t2_ready_w2", 32'(ready), 0);
    @(negedge clk);
    check("t2_ready_w3", 32'(ready), 0);
    @(negedge clk);
    check("t2_ready_rise", 32'(ready), 1);
    @(negedge clk);
    check("t2_wr_done", 32'(wr_done), 1);
    handshake_in = 1'b1;
    @(negedge clk);
    handshake_in = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_wr_count", 32'(wr_count), 2);
    check("t3_ready", 32'(ready), 0);
    check("t3_err", 32'(err), 0);
    check_mem("t3_mem");

    // Valid withdrawn during S_wait: abort, error, nothing written.
    @(negedge clk);
    wait_cfg = 2'd2; addr_in = 3'd1; value_in = 3'd3; valid = 1'b1;
    @(negedge clk);
    check("t4_ready_wait", 32'(ready), 0);
    valid = 1'b0;
    @(negedge clk);
    check("t4_err", 32'(err), 1);
    check("t4_ready", 32'(ready), 0);
    repeat (4) @(negedge clk);
    check("t4_ready_later", 32'(ready), 0);
    check("t4_wr_count", 32'(wr_count), 2);
    check_mem("t4_mem");

    // Missing handshake: error after two S_ack cycles, write still committed.
    apply_reset();
    @(negedge clk);
    wait_cfg = 2'd0; addr_in = 3'd4; value_in = 3'd5; valid = 1'b1;
    push_exp(3'd4, 3'd5, 1'b0);
    @(negedge clk);
    check("t5_ready", 32'(ready), 1);
    @(negedge clk);
    check("t5_wr_done", 32'(wr_done), 1);
    valid = 1'b0;
    @(negedge clk);
    check("t5_err_early", 32'(err), 0);
    @(negedge clk);
    check("t5_err_timeout", 32'(err), 1);
    check("t5_ready_idle", 32'(ready), 0);
    rd_addr = 3'd4;
    #1;
    check("t5_rd_data", 32'(rd_data), 5);
    check("t5_wr_count", 32'(wr_count), 1);
    do_write(2'd0, 3'd6, 3'd1, 1'b1);
    check("t5_wr_count2", 32'(wr_count), 2);
    check_mem("t5_mem");

    // Address changes while waiting: error, but captured values are written.
    apply_reset();
    @(negedge clk);
    wait_cfg = 2'd1; addr_in = 3'd3; value_in = 3'd2; valid = 1'b1;
    push_exp(3'd3, 3'd2, 1'b1);
    @(negedge clk);
    check("t6_err_before", 32'(err), 0);
    addr_in = 3'd7;
    @(negedge clk);
    check("t6_ready", 32'(ready), 1);
    check("t6_err", 32'(err), 1);
    @(negedge clk);
    handshake_in = 1'b1;
    @(negedge clk);
    handshake_in = 1'b0; valid = 1'b0;
    check_mem("t6_mem");

    // Stray handshake while idle.
    apply_reset();
    @(negedge clk);
    handshake_in = 1'b1;
    @(negedge clk);
    handshake_in = 1'b0;
    check("t7_err", 32'(err), 1);
    check("t7_ready", 32'(ready), 0);

    // Asynchronous reset while ready=1, then counter saturation.
    apply_reset();
    do_write(2'd0, 3'd0, 3'd5, 1'b0);
    @(negedge clk);
    wait_cfg = 2'd0; addr_in = 3'd1; value_in = 3'd3; valid = 1'b1;
    @(negedge clk);
    check("t8_ready_pre", 32'(ready), 1);
    check("t8_count_pre", 32'(wr_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_async_ready", 32'(ready), 0);
    check("t8_async_count", 32'(wr_count), 0);
    check("t8_async_done", 32'(wr_done), 0);
    check("t8_async_err", 32'(err), 0);
    rd_addr = 3'd0;
    #1;
    check("t8_async_mem", 32'(rd_data), 0);
    valid = 1'b0;
    for (int i = 0; i < 8; i++) tb_mem[i] = '0;
    exp_count = 0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      do_write(2'd0, 3'(i), 3'(i + 1), 1'b0);
    end
    repeat (2) @(negedge clk);
    check("t8_saturated", 32'(wr_count), 255);
    check("t8_err", 32'(err), 0);
    check_mem("t8_mem");
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
